alu_arb: RTL

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_arb.sv | 112 +++++++++++
 1 files changed

// File: rtl/alu_arb.sv
// Two-requester front end for a single shared combinational ALU: arbitrates, registers
// the winning operands for one execute cycle, then holds the result until it is taken.
`ifndef ALU_NOP
`define ALU_NOP 4'hF
`endif

module alu_arb #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic [4:0]  req0_shamt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  input  logic [4:0]  req1_shamt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_c,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_c,
  output logic        rsp_zero,
  output logic        rsp_id,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  shamt;
    logic        id;
  } opr_t;

  state_t state, state_nx;
  opr_t   opr;
  logic   last_grant;
  logic   accept;
  logic   win_id;
  logic   fire;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // through the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    accept   = (state == IDLE) || (state == HOLD && rsp_ready);

    // With both requesting, round-robin picks the one not served last.
    if (req0_valid && req1_valid) win_id = PRIO_FIXED ? 1'b0 : ~last_grant;
    else                          win_id = req1_valid;

    fire       = rstn && accept && (req0_valid || req1_valid);
    req0_ready = fire && !win_id;
    req1_ready = fire && win_id;

    case (state)
      IDLE:    if (fire) state_nx = EXEC;
      EXEC:    state_nx = HOLD;
      HOLD:    if (rsp_ready) state_nx = fire ? EXEC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy      = rstn && (state != IDLE);
  assign alu_a     = (state == EXEC) ? opr.a     : 32'd0;
  assign alu_b     = (state == EXEC) ? opr.b     : 32'd0;
  assign alu_op    = (state == EXEC) ? opr.op    : `ALU_NOP;
  assign alu_shamt = (state == EXEC) ? opr.shamt : 5'd0;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      opr        <= '0;
      rsp_valid  <= 1'b0;
      rsp_c      <= 32'd0;
      rsp_zero   <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      state <= state_nx;
      if (fire) begin
        opr        <= win_id ? {req1_a, req1_b, req1_op, req1_shamt, 1'b1}
                             : {req0_a, req0_b, req0_op, req0_shamt, 1'b0};
        last_grant <= win_id;
      end
      if (state == EXEC) begin
        rsp_c     <= alu_c;
        rsp_zero  <= alu_zero;
        rsp_id    <= opr.id;
        rsp_valid <= 1'b1;
      end else if (state == HOLD && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
